// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with toggle/tick modes.
// Config writes are shadowed and applied only at period boundaries.
module clk_div_multi #(
  parameter int N_CH        = 4,
  parameter int DIV_W       = 16,
  parameter int CH_W        = 2,
  parameter int DEFAULT_DIV = 4
) (
  input  logic              I_CLK,
  input  logic              rst,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [N_CH-1:0]   O_CLK,
  output logic [N_CH-1:0]   O_TICK,
  output logic [N_CH-1:0]   pend
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] act_div;
    logic [DIV_W-1:0] sh_div;
    logic             act_mode;
    logic             sh_mode;
    logic             pnd;
    logic             oclk;
    logic             otick;
    logic             wr;
    logic             run;
    logic             term;
    logic             nxt_mode;

    always_comb begin
      wr       = cfg_we && (cfg_ch == CH_W'(i));
      run      = ch_en[i] && (act_div != '0);
      term     = (cnt == act_div - 1'b1);
      nxt_mode = pnd ? sh_mode : act_mode;
    end

    always_ff @(posedge I_CLK) begin
      if (rst) begin
        cnt      <= '0;
        act_div  <= DIV_W'(DEFAULT_DIV);
        sh_div   <= DIV_W'(DEFAULT_DIV);
        act_mode <= 1'b0;
        sh_mode  <= 1'b0;
        pnd      <= 1'b0;
        oclk     <= 1'b0;
        otick    <= 1'b0;
      end else begin
        if (!run) begin
          cnt   <= '0;
          oclk  <= 1'b0;
          otick <= 1'b0;
          if (pnd) begin
            act_div  <= sh_div;
            act_mode <= sh_mode;
            pnd      <= 1'b0;
          end
        end else if (term) begin
          cnt   <= '0;
          otick <= 1'b1;
          // output follows the mode that governs the next period
          oclk  <= nxt_mode ? 1'b1 : ~oclk;
          if (pnd) begin
            act_div  <= sh_div;
            act_mode <= sh_mode;
            pnd      <= 1'b0;
          end
        end else begin
          cnt   <= cnt + 1'b1;
          otick <= 1'b0;
          if (act_mode) oclk <= 1'b0;
        end
        // a write in the same cycle as an apply stays pending
        if (wr) begin
          sh_div  <= cfg_div;
          sh_mode <= cfg_mode;
          pnd     <= 1'b1;
        end
      end
    end

    assign O_CLK[i]  = oclk;
    assign O_TICK[i] = otick;
    assign pend[i]   = pnd;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed steps then random
// traffic against a period-based reference model (4- and 3-channel DUTs).
module tb_clk_div_multi;

  logic        I_CLK = 1'b0;
  logic        rst;
  logic [3:0]  ch_en;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_mode;
  logic [3:0]  clk_a, tick_a, pend_a;
  logic [2:0]  clk_b, tick_b, pend_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 I_CLK = ~I_CLK;

  clk_div_multi dut_a (
    .I_CLK(I_CLK), .rst(rst), .ch_en(ch_en),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_mode(cfg_mode),
    .O_CLK(clk_a), .O_TICK(tick_a), .pend(pend_a)
  );

  clk_div_multi #(.N_CH(3)) dut_b (
    .I_CLK(I_CLK), .rst(rst), .ch_en(ch_en[2:0]),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_mode(cfg_mode),
    .O_CLK(clk_b), .O_TICK(tick_b), .pend(pend_b)
  );

  // model: cycles elapsed in current period, level, pending shadow
  int m_pos  [2][4];
  int m_r    [2][4];
  int m_sr   [2][4];
  bit m_mode [2][4];
  bit m_smode[2][4];
  bit m_pend [2][4];
  bit m_clk  [2][4];
  bit m_tick [2][4];

  function automatic int nch(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic apply_shadow(int k, int c);
    if (m_pend[k][c]) begin
      m_r[k][c]    = m_sr[k][c];
      m_mode[k][c] = m_smode[k][c];
      m_pend[k][c] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < nch(k); c++) begin
        if (rst) begin
          m_pos[k][c] = 0; m_r[k][c] = 4; m_sr[k][c] = 4;
          m_mode[k][c] = 0; m_smode[k][c] = 0; m_pend[k][c] = 0;
          m_clk[k][c] = 0; m_tick[k][c] = 0;
        end else begin
          if (!ch_en[c] || m_r[k][c] == 0) begin
            m_pos[k][c] = 0; m_clk[k][c] = 0; m_tick[k][c] = 0;
            apply_shadow(k, c);
          end else begin
            m_pos[k][c]++;
            if (m_pos[k][c] == m_r[k][c]) begin
              m_pos[k][c] = 0;
              m_tick[k][c] = 1;
              apply_shadow(k, c);
              m_clk[k][c] = m_mode[k][c] ? 1'b1 : !m_clk[k][c];
            end else begin
              m_tick[k][c] = 0;
              if (m_mode[k][c]) m_clk[k][c] = 0;
            end
          end
          if (cfg_we && int'(cfg_ch) == c) begin
            m_sr[k][c] = int'(cfg_div);
            m_smode[k][c] = cfg_mode;
            m_pend[k][c] = 1'b1;
          end
        end
      end
    end
  endtask

  function automatic logic [3:0] expv(int k, int w);
    logic [3:0] v = '0;
    for (int c = 0; c < nch(k); c++)
      v[c] = (w == 0) ? m_clk[k][c] : (w == 1) ? m_tick[k][c] : m_pend[k][c];
    return v;
  endfunction

  task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge I_CLK);
    model_step();
    #1;
    check("clk_a", clk_a, expv(0, 0));
    check("tick_a", tick_a, expv(0, 1));
    check("pend_a", pend_a, expv(0, 2));
    check("clk_b", {1'b0, clk_b}, expv(1, 0));
    check("tick_b", {1'b0, tick_b}, expv(1, 1));
    check("pend_b", {1'b0, pend_b}, expv(1, 2));
  endtask

  task automatic wr(logic [1:0] ch, logic [15:0] dv, logic md);
    cfg_we = 1'b1; cfg_ch = ch; cfg_div = dv; cfg_mode = md;
    cyc();
    cfg_we = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++) begin
        m_pos[k][c] = 0; m_r[k][c] = 0; m_sr[k][c] = 0;
        m_mode[k][c] = 0; m_smode[k][c] = 0; m_pend[k][c] = 0;
        m_clk[k][c] = 0; m_tick[k][c] = 0;
      end
    rst = 1'b1; ch_en = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_div = '0; cfg_mode = 1'b0;
    cyc(); cyc();
    check("rst_clk", clk_a, 4'b0000);
    check("rst_pend", pend_a, 4'b0000);

    // defaults: ch0 divide by 4, toggle
    rst = 1'b0; ch_en = 4'b0001;
    cyc(); cyc(); cyc();
    check("rise_early", {3'b0, clk_a[0]}, 4'b0000);
    cyc();
    check("rise4_clk", {3'b0, clk_a[0]}, 4'b0001);
    check("rise4_tick", {3'b0, tick_a[0]}, 4'b0001);
    check("others_idle", {1'b0, clk_a[3:1]}, 4'b0000);
    cyc();
    wr(2'd0, 16'd2, 1'b0);
    check("pend0_set", {3'b0, pend_a[0]}, 4'b0001);
    repeat (10) cyc();

    // ch1 tick mode divide by 3
    wr(2'd1, 16'd3, 1'b1);
    cyc();
    ch_en = 4'b0011;
    cyc(); cyc();
    check("tick1_early", {3'b0, tick_a[1]}, 4'b0000);
    cyc();
    check("tick1_third", {3'b0, tick_a[1]}, 4'b0001);
    check("clk1_third", {3'b0, clk_a[1]}, 4'b0001);
    repeat (6) cyc();

    // ch2 ratio edge cases
    wr(2'd2, 16'd1, 1'b0);
    cyc();
    ch_en = 4'b0111;
    cyc();
    check("r1_tog_hi", {3'b0, clk_a[2]}, 4'b0001);
    cyc();
    check("r1_tog_lo", {3'b0, clk_a[2]}, 4'b0000);
    wr(2'd2, 16'd1, 1'b1);
    repeat (3) cyc();
    check("r1_tick_hi", {3'b0, tick_a[2]}, 4'b0001);
    wr(2'd2, 16'd0, 1'b0);
    cyc();
    check("r0_pend_clr", {3'b0, pend_a[2]}, 4'b0000);
    repeat (2) cyc();
    check("r0_idle", {3'b0, clk_a[2] | tick_a[2]}, 4'b0000);

    // ch3 write on its terminal cycle
    ch_en = 4'b1111;
    cyc(); cyc(); cyc();
    wr(2'd3, 16'd2, 1'b1);
    check("term_wr_tick", {3'b0, tick_a[3]}, 4'b0001);
    check("term_wr_pend", {3'b0, pend_a[3]}, 4'b0001);
    cyc(); cyc(); cyc();
    check("term_wr_hold", {3'b0, pend_a[3]}, 4'b0001);
    cyc();
    check("term_wr_apply", {3'b0, pend_a[3]}, 4'b0000);
    repeat (4) cyc();
    check("oor_pend_b", {1'b0, pend_b}, 4'b0000);

    // reset mid-period with a pending write
    wr(2'd0, 16'd5, 1'b0);
    rst = 1'b1;
    cyc();
    check("rst2_clk", clk_a, 4'b0000);
    check("rst2_tick", tick_a, 4'b0000);
    check("rst2_pend", pend_a, 4'b0000);
    rst = 1'b0; ch_en = 4'b0001;
    cyc(); cyc();
    ch_en = 4'b0000;
    cyc();
    ch_en = 4'b0001;
    cyc(); cyc(); cyc();
    check("reen_early", {3'b0, tick_a[0]}, 4'b0000);
    cyc();
    check("reen_tick", {3'b0, tick_a[0]}, 4'b0001);

    // random traffic
    repeat (3000) begin
      rst = ($urandom_range(499) == 0);
      if ($urandom_range(15) == 0) ch_en = 4'($urandom);
      cfg_we = ($urandom_range(5) == 0);
      cfg_ch = 2'($urandom);
      cfg_div = 16'($urandom_range(6));
      cfg_mode = 1'($urandom);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Multi-channel programmable clock divider. Generalises the fixed divide-by-2·num toggle divider.
- Each of N_CH channels has:
  - a runtime-programmable ratio R;
  - a selectable mode: 50 % toggle clock, or single-cycle tick;
  - its own enable.
- Ratio and mode updates are shadowed and applied only at a period boundary, so output periods are never truncated.
- Sits beside the CPU core and generates slow clocks / clock-enables for display scan, UART baud and debug stepping.

Parameters:
- N_CH, 4, number of independent divider channels.
- DIV_W, 16, width of ratio R per channel.
- CH_W, 2, width of cfg_ch channel index; must satisfy 2^CH_W >= N_CH.
- DEFAULT_DIV, 4, reset value of R for every channel.

Ports:
- I_CLK  in  1  input clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- ch_en  in  N_CH  per-channel enable; bit i controls channel i.
- cfg_we  in  1  configuration write strobe, one cycle.
- cfg_ch  in  CH_W  channel index for the write.
- cfg_div  in  DIV_W  new ratio R.
- cfg_mode  in  1  new mode: 0 = toggle, 1 = tick.
- O_CLK  out  N_CH  divided clock per channel (registered).
- O_TICK  out  N_CH  one-cycle pulse per channel at each terminal count (registered).
- pend  out  N_CH  bit i high while channel i has an unapplied configuration.

Behaviour:
- State per channel:
  - counter cnt (DIV_W);
  - active R and active mode;
  - shadow R and shadow mode;
  - pend flag.
- Reset (rst=1 on posedge), all channels: cnt=0, active R=shadow R=DEFAULT_DIV, mode=0, O_CLK=0, O_TICK=0, pend=0. Reset overrides any cfg_we in the same cycle.
- Config write (cfg_we=1):
  - Loads cfg_div/cfg_mode into the shadow of channel cfg_ch and sets pend[cfg_ch].
  - If cfg_ch >= N_CH the write is ignored.
  - A write while pend is already set overwrites the shadow; last write wins.
- Enabled channel (ch_en=1, active R>0):
  - Terminal count is cnt==R-1. Otherwise cnt increments and O_TICK=0.
  - Toggle mode, non-terminal: O_CLK holds.
  - Tick mode, non-terminal: O_CLK=0.
  - At terminal: cnt<=0 and O_TICK<=1.
  - At terminal with pend=1: active R/mode <= shadow, pend<=0. The new R governs the next period.
  - At terminal, O_CLK next value uses the mode in effect after any update: toggle mode gives ~O_CLK; tick mode gives 1.
- Resulting timing:
  - Toggle mode: O_CLK period 2R cycles, 50 % duty, first rising edge R cycles after enable.
  - Tick mode: O_CLK = O_TICK, one-cycle high every R cycles.
- R=1:
  - Toggle mode: O_CLK toggles every cycle (period 2).
  - Tick mode: O_TICK and O_CLK stay high continuously.
- Disabled channel (ch_en=0, or active R==0):
  - cnt<=0, O_CLK<=0, O_TICK<=0.
  - A pending update applies immediately, on the next edge, and pend clears.
  - A channel whose shadow R is 0 ends up disabled until rewritten.
- Re-enable: counting restarts from cnt=0; first terminal occurs R cycles after ch_en rises.
- Write on the same cycle as that channel's terminal:
  - The terminal applies the previously pending shadow, if any.
  - The new write becomes pending and takes effect at the following terminal.
  - pend stays 1.
- Channels are fully independent; simultaneous writes to different channels are impossible (single write port).
- Reset mid-period: immediate return to reset state; no partial pulse follows.

Test Plan:
- Reset, ch_en=4'b0001, defaults -> O_CLK[0] rises 4 cycles after rst deasserts; period 8, high 4; O_TICK[0] pulses every 4 cycles; other channels stay 0.
- Mid-period, write ch0 div=2 mode=0 -> pend[0]=1 until the current 4-cycle half-period completes, then clears; subsequent O_CLK[0] period 4; no short pulse.
- Write ch1 div=3 mode=1, then enable ch1 -> O_CLK[1] = O_TICK[1], high 1 cycle every 3 cycles, first pulse on the 3rd cycle after enable.
- Ratio edge cases:
  - ch2 div=1 mode=0 -> O_CLK[2] toggles every cycle.
  - div=1 mode=1 -> O_TICK[2] constantly 1.
  - div=0 -> O_CLK[2], O_TICK[2] held 0, pend[2] clears next cycle.
- Write ch3 exactly on its terminal cycle -> old config used for one more period, new config from the next terminal; cfg_ch out of range (when N_CH < 2^CH_W) -> no pend change.
- Assert rst mid-period with pend set -> all outputs 0, pend=0, R back to DEFAULT_DIV; disabling then re-enabling restarts at cnt 0.
